// File: rtl/hex_counter_pkg.sv
// Shared types and helpers for the hex rate counter and its rate divider.
package hex_counter_pkg;

  // Width of one displayed hex digit
  localparam int DIGIT_W = 4;

  // Rate selection encoding as it arrives on the 2-bit speed input
  typedef enum logic [1:0] {
    SPD_FULL    = 2'b00,
    SPD_1HZ     = 2'b01,
    SPD_HALF    = 2'b10,
    SPD_QUARTER = 2'b11
  } speed_t;

  // Tick period in clock cycles for a given rate selection
  function automatic int period_of(input speed_t spd, input int clk_hz);
    int p;
    case (spd)
      SPD_FULL:    p = 1;
      SPD_1HZ:     p = clk_hz;
      SPD_HALF:    p = 2 * clk_hz;
      SPD_QUARTER: p = 4 * clk_hz;
      default:     p = 1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Rate divider: a down-counter that produces a count-enable (fire) every P
// enabled cycles, where P is chosen by speed at the moment the counter reloads.
module rate_divider
  import hex_counter_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] speed,
  input  logic       restart,
  output logic       fire
);

  // Wide enough to hold the longest reload value, 4*CLK_HZ-1
  localparam int CNT_W = $clog2(4 * CLK_HZ);

  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] reload_val;
  speed_t           spd;

  assign spd  = speed_t'(speed);
  assign fire = en && (rd_cnt == '0);

  // Reload value P-1 for the currently selected rate
  always_comb begin
    reload_val = CNT_W'(period_of(spd, CLK_HZ) - 1);
  end

  // Interval counter: restart and fire both begin a fresh interval, speed is
  // only looked at here so a mid-interval change waits for the next reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (restart || fire) begin
      rd_cnt <= reload_val;
    end else if (en) begin
      rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Multi-digit up/down hex counter stepped by a selectable-rate divider,
// feeding one nibble per seven-segment decoder plus tick/wrap status pulses.
module hex_rate_counter
  import hex_counter_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic [1:0]                speed,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] digits,
  output logic                      tick,
  output logic                      wrap
);

  localparam int W = DIGIT_W * DIGITS;

  logic         fire;
  logic [W-1:0] count_next;
  logic         wrap_next;

  // A load restarts the interval so the next step lands a full period later
  rate_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_rate_divider (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .speed  (speed),
    .restart(load),
    .fire   (fire)
  );

  // Next count in plain binary, nibbles carry/borrow into their neighbours
  always_comb begin
    count_next = digits;
    wrap_next  = 1'b0;
    if (up) begin
      count_next = digits + W'(1);
      wrap_next  = (digits == {W{1'b1}});
    end else begin
      count_next = digits - W'(1);
      wrap_next  = (digits == '0);
    end
  end

  // Counter and status flags: load beats fire beats hold, pulses align with
  // the first cycle the new count is visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      digits <= load_val;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (fire) begin
      digits <= count_next;
      tick   <= 1'b1;
      wrap   <= wrap_next;
    end else begin
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end
  end

endmodule
